// File: rtl/vga_mem_arbiter.sv
// Shares the single-ported video memory between the display fetch port (priority)
// and the host Wishbone port; a starvation counter guarantees the host a slot.
module vga_mem_arbiter #(
  parameter int LAT       = 1,
  parameter int HOST_SLOT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] csr_adr_i,
  input  logic        csr_stb_i,
  output logic [15:0] csr_dat_o,
  output logic        csr_ack_o,
  input  logic        disp_urgent,
  input  logic [16:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [16:0] mem_adr_o,
  output logic [15:0] mem_dat_o,
  input  logic [15:0] mem_dat_i,
  output logic [1:0]  mem_sel_o,
  output logic        mem_we_o,
  output logic        mem_stb_o
);

  typedef enum logic [1:0] {IDLE, DISP, HOST, ACK} state_t;

  localparam logic [3:0] SLOT     = 4'(HOST_SLOT);
  localparam logic [2:0] LAT_LAST = 3'(LAT - 1);

  state_t     state, state_nxt;
  logic [2:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       own_host;
  logic       disp_req, host_req, host_slot;
  logic       grant_host, grant_disp, access_done;

  function automatic logic [3:0] starve_sat_inc(input logic [3:0] cnt);
    return (cnt >= SLOT) ? SLOT : cnt + 4'd1;
  endfunction

  assign disp_req    = csr_stb_i;
  assign host_req    = wb_stb_i & wb_cyc_i;
  assign host_slot   = (starve_cnt == SLOT) & ~disp_urgent;
  assign access_done = ((state == DISP) || (state == HOST)) && (lat_cnt == 3'd0);

  // A host that abandoned its strobe mid-access gets no ack; the display always does.
  assign csr_ack_o = (state == ACK) & ~own_host;
  assign wb_ack_o  = (state == ACK) & own_host & host_req;

  always_comb begin
    state_nxt  = state;
    grant_host = 1'b0;
    grant_disp = 1'b0;
    case (state)
      IDLE: begin
        if (host_req & (~disp_req | host_slot)) begin
          grant_host = 1'b1;
          state_nxt  = HOST;
        end else if (disp_req) begin
          grant_disp = 1'b1;
          state_nxt  = DISP;
        end
      end
      DISP, HOST: if (lat_cnt == 3'd0) state_nxt = ACK;
      ACK:        state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_adr_o  <= '0;
      mem_dat_o  <= '0;
      mem_sel_o  <= '0;
      mem_we_o   <= 1'b0;
      mem_stb_o  <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      own_host   <= 1'b0;
      csr_dat_o  <= '0;
      wb_dat_o   <= '0;
    end else begin
      if (grant_host) begin
        mem_adr_o  <= wb_adr_i;
        mem_dat_o  <= wb_dat_i;
        mem_sel_o  <= wb_sel_i;
        mem_we_o   <= wb_we_i;
        mem_stb_o  <= 1'b1;
        lat_cnt    <= LAT_LAST;
        own_host   <= 1'b1;
        starve_cnt <= '0;
      end else if (grant_disp) begin
        mem_adr_o  <= csr_adr_i;
        mem_sel_o  <= 2'b11;
        mem_we_o   <= 1'b0;
        mem_stb_o  <= 1'b1;
        lat_cnt    <= LAT_LAST;
        own_host   <= 1'b0;
        starve_cnt <= host_req ? starve_sat_inc(starve_cnt) : 4'd0;
      end else if ((state == IDLE) && !host_req) begin
        starve_cnt <= '0;
      end
      // Memory data is valid on the last strobe cycle; route it to the owner.
      if (access_done) begin
        mem_stb_o <= 1'b0;
        mem_we_o  <= 1'b0;
        if (own_host) wb_dat_o  <= mem_dat_i;
        else          csr_dat_o <= mem_dat_i;
      end else if ((state == DISP) || (state == HOST)) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: LAT=1 and LAT=3 instances against a transaction-timeline model.
module tb_vga_mem_arbiter;
  localparam int HOST_SLOT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] csr_adr     [2];
  logic        csr_stb     [2];
  logic [15:0] csr_dat     [2];
  logic        csr_ack     [2];
  logic        disp_urgent [2];
  logic [16:0] wb_adr      [2];
  logic [15:0] wb_dat_w    [2];
  logic [1:0]  wb_sel      [2];
  logic        wb_we       [2];
  logic        wb_stb      [2];
  logic        wb_cyc      [2];
  logic [15:0] wb_dat_r    [2];
  logic        wb_ack      [2];
  logic [16:0] mem_adr     [2];
  logic [15:0] mem_dat_w   [2];
  logic [15:0] mem_dat_r   [2];
  logic [1:0]  mem_sel     [2];
  logic        mem_we      [2];
  logic        mem_stb     [2];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  vga_mem_arbiter #(.LAT(1), .HOST_SLOT(HOST_SLOT)) u_lat1 (
    .clk(clk), .rst(rst),
    .csr_adr_i(csr_adr[0]), .csr_stb_i(csr_stb[0]), .csr_dat_o(csr_dat[0]), .csr_ack_o(csr_ack[0]),
    .disp_urgent(disp_urgent[0]),
    .wb_adr_i(wb_adr[0]), .wb_dat_i(wb_dat_w[0]), .wb_sel_i(wb_sel[0]), .wb_we_i(wb_we[0]),
    .wb_stb_i(wb_stb[0]), .wb_cyc_i(wb_cyc[0]), .wb_dat_o(wb_dat_r[0]), .wb_ack_o(wb_ack[0]),
    .mem_adr_o(mem_adr[0]), .mem_dat_o(mem_dat_w[0]), .mem_dat_i(mem_dat_r[0]),
    .mem_sel_o(mem_sel[0]), .mem_we_o(mem_we[0]), .mem_stb_o(mem_stb[0])
  );

  vga_mem_arbiter #(.LAT(3), .HOST_SLOT(HOST_SLOT)) u_lat3 (
    .clk(clk), .rst(rst),
    .csr_adr_i(csr_adr[1]), .csr_stb_i(csr_stb[1]), .csr_dat_o(csr_dat[1]), .csr_ack_o(csr_ack[1]),
    .disp_urgent(disp_urgent[1]),
    .wb_adr_i(wb_adr[1]), .wb_dat_i(wb_dat_w[1]), .wb_sel_i(wb_sel[1]), .wb_we_i(wb_we[1]),
    .wb_stb_i(wb_stb[1]), .wb_cyc_i(wb_cyc[1]), .wb_dat_o(wb_dat_r[1]), .wb_ack_o(wb_ack[1]),
    .mem_adr_o(mem_adr[1]), .mem_dat_o(mem_dat_w[1]), .mem_dat_i(mem_dat_r[1]),
    .mem_sel_o(mem_sel[1]), .mem_we_o(mem_we[1]), .mem_stb_o(mem_stb[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s lat%0d got=%0h exp=%0h t=%0t", name, lat_of(k), act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s got=%s exp=%s", name, act, exp);
    end
  endtask

  // Model: an access is a timeline counted from its grant edge. Cycles 1..LAT
  // carry the strobe, cycle LAT+1 the ack, and the next decision follows.
  bit          m_act    [2];
  int          m_off    [2];
  bit          m_host   [2];
  int          m_starve [2];
  logic [16:0] e_adr    [2];
  logic [1:0]  e_sel    [2];
  bit          e_we     [2];
  logic [15:0] e_mdat   [2];
  logic [15:0] e_csr_dat[2];
  logic [15:0] e_wb_dat [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_act[k] <= 1'b0; m_off[k] <= 0; m_host[k] <= 1'b0; m_starve[k] <= 0;
        e_adr[k] <= '0; e_sel[k] <= '0; e_we[k] <= 1'b0; e_mdat[k] <= '0;
        e_csr_dat[k] <= '0; e_wb_dat[k] <= '0;
      end else if (!m_act[k]) begin
        if ((wb_stb[k] && wb_cyc[k]) &&
            (!csr_stb[k] || (m_starve[k] == HOST_SLOT && !disp_urgent[k]))) begin
          m_act[k] <= 1'b1; m_off[k] <= 1; m_host[k] <= 1'b1; m_starve[k] <= 0;
          e_adr[k] <= wb_adr[k]; e_sel[k] <= wb_sel[k]; e_we[k] <= wb_we[k]; e_mdat[k] <= wb_dat_w[k];
        end else if (csr_stb[k]) begin
          m_act[k] <= 1'b1; m_off[k] <= 1; m_host[k] <= 1'b0;
          e_adr[k] <= csr_adr[k]; e_sel[k] <= 2'b11; e_we[k] <= 1'b0;
          if (wb_stb[k] && wb_cyc[k])
            m_starve[k] <= (m_starve[k] + 1 > HOST_SLOT) ? HOST_SLOT : m_starve[k] + 1;
          else
            m_starve[k] <= 0;
        end else begin
          m_starve[k] <= 0;
        end
      end else begin
        if (m_off[k] == lat_of(k)) begin
          if (m_host[k]) e_wb_dat[k]  <= mem_dat_r[k];
          else           e_csr_dat[k] <= mem_dat_r[k];
        end
        if (m_off[k] == lat_of(k) + 1) m_act[k] <= 1'b0;
        else                           m_off[k] <= m_off[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit es, ea;
      es = m_act[k] && (m_off[k] <= lat_of(k));
      ea = m_act[k] && (m_off[k] == lat_of(k) + 1);
      chk("mem_stb", k, 32'(mem_stb[k]), 32'(es));
      chk("mem_we", k, 32'(mem_we[k]), 32'(es && e_we[k]));
      chk("mem_adr", k, 32'(mem_adr[k]), 32'(e_adr[k]));
      chk("mem_sel", k, 32'(mem_sel[k]), 32'(e_sel[k]));
      if (es && e_we[k]) chk("mem_dat", k, 32'(mem_dat_w[k]), 32'(e_mdat[k]));
      chk("csr_ack", k, 32'(csr_ack[k]), 32'(ea && !m_host[k]));
      chk("wb_ack", k, 32'(wb_ack[k]), 32'(ea && m_host[k] && wb_stb[k] && wb_cyc[k]));
      chk("csr_dat", k, 32'(csr_dat[k]), 32'(e_csr_dat[k]));
      chk("wb_dat", k, 32'(wb_dat_r[k]), 32'(e_wb_dat[k]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    int    ack_i, n_wb, n_csr, n_stb;
    string seq;
    for (int k = 0; k < 2; k++) begin
      csr_adr[k] = '0; csr_stb[k] = 1'b0; disp_urgent[k] = 1'b0;
      wb_adr[k] = '0; wb_dat_w[k] = '0; wb_sel[k] = '0; wb_we[k] = 1'b0;
      wb_stb[k] = 1'b0; wb_cyc[k] = 1'b0; mem_dat_r[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_stb", k, 32'(mem_stb[k]), 32'd0);
      chk("rst_we", k, 32'(mem_we[k]), 32'd0);
      chk("rst_adr", k, 32'(mem_adr[k]), 32'd0);
      chk("rst_mdat", k, 32'(mem_dat_w[k]), 32'd0);
      chk("rst_sel", k, 32'(mem_sel[k]), 32'd0);
      chk("rst_acks", k, 32'({csr_ack[k], wb_ack[k]}), 32'd0);
      chk("rst_dat", k, 32'({csr_dat[k], wb_dat_r[k]}), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Display read on LAT=1: strobe in cycle 1, ack in cycle 2
    #1 csr_adr[0] = 17'h00100; mem_dat_r[0] = 16'hA55A; csr_stb[0] = 1'b1;
    ack_i = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("d_stb_c1", 0, 32'(mem_stb[0]), 32'd1);
        chk("d_adr_c1", 0, 32'(mem_adr[0]), 32'h00100);
        chk("d_sel_c1", 0, 32'(mem_sel[0]), 32'd3);
      end
      if (csr_ack[0] && ack_i < 0) begin
        ack_i = i;
        chk("d_csr_dat", 0, 32'(csr_dat[0]), 32'hA55A);
        #1 csr_stb[0] = 1'b0;
      end
    end
    chk("d_ack_cycle", 0, 32'(ack_i), 32'd2);

    // Host write on LAT=1 with display idle
    @(posedge clk); #1;
    wb_adr[0] = 17'h1FFFF; wb_dat_w[0] = 16'h1234; wb_sel[0] = 2'b01; wb_we[0] = 1'b1;
    wb_stb[0] = 1'b1; wb_cyc[0] = 1'b1;
    n_wb = 0; n_csr = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("hw_we", 0, 32'(mem_we[0]), 32'd1);
        chk("hw_sel", 0, 32'(mem_sel[0]), 32'd1);
        chk("hw_adr", 0, 32'(mem_adr[0]), 32'h1FFFF);
        chk("hw_dat", 0, 32'(mem_dat_w[0]), 32'h1234);
      end
      if (csr_ack[0]) n_csr++;
      if (wb_ack[0]) begin
        n_wb++;
        #1 wb_stb[0] = 1'b0; wb_cyc[0] = 1'b0; wb_we[0] = 1'b0;
      end
    end
    chk("hw_wb_acks", 0, 32'(n_wb), 32'd1);
    chk("hw_csr_acks", 0, 32'(n_csr), 32'd0);

    // Both requesting continuously, host reads: starvation guard interleaves
    @(posedge clk); #1;
    csr_adr[0] = 17'h00200; csr_stb[0] = 1'b1;
    wb_adr[0] = 17'h00300; wb_sel[0] = 2'b11; wb_we[0] = 1'b0; wb_stb[0] = 1'b1; wb_cyc[0] = 1'b1;
    seq = "";
    for (int i = 0; i < 200 && seq.len() < 10; i++) begin
      @(negedge clk);
      if (csr_ack[0]) seq = {seq, "D"};
      if (wb_ack[0])  seq = {seq, "H"};
      mem_dat_r[0] = mem_dat_r[0] + 16'h1111;
    end
    chk_str("grant_seq", seq, "DDDDHDDDDH");
    @(posedge clk); #1 csr_stb[0] = 1'b0; wb_stb[0] = 1'b0; wb_cyc[0] = 1'b0;
    repeat (2) @(posedge clk);

    // Urgent display blocks the host slot entirely
    #1 csr_stb[0] = 1'b1; wb_stb[0] = 1'b1; wb_cyc[0] = 1'b1; disp_urgent[0] = 1'b1;
    n_wb = 0; n_csr = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (csr_ack[0]) n_csr++;
      if (wb_ack[0])  n_wb++;
    end
    chk("urg_host_acks", 0, 32'(n_wb), 32'd0);
    chk("urg_disp_acks", 0, 32'(n_csr), 32'd13);
    ack_i = -1;
    for (int i = 0; i < 20 && ack_i < 0; i++) begin
      @(negedge clk);
      if (csr_ack[0]) ack_i = i;
    end
    chk("urg_disp_ack_seen", 0, 32'(ack_i >= 0), 32'd1);
    @(posedge clk); #1 disp_urgent[0] = 1'b0;
    ack_i = -1; n_csr = 0;
    for (int i = 0; i < 20 && ack_i < 0; i++) begin
      @(negedge clk);
      if (csr_ack[0]) n_csr++;
      if (wb_ack[0]) ack_i = i;
    end
    chk("urg_release_host", 0, 32'(ack_i >= 0), 32'd1);
    chk("urg_release_no_disp", 0, 32'(n_csr), 32'd0);
    @(posedge clk); #1 csr_stb[0] = 1'b0; wb_stb[0] = 1'b0; wb_cyc[0] = 1'b0;
    repeat (2) @(posedge clk);

    // LAT=3: host abandons a write mid-access
    #1 wb_adr[1] = 17'h0ABCD; wb_dat_w[1] = 16'hBEEF; wb_sel[1] = 2'b10; wb_we[1] = 1'b1;
    wb_stb[1] = 1'b1; wb_cyc[1] = 1'b1;
    n_stb = 0; n_wb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_stb[1]) n_stb++;
      if (wb_ack[1])  n_wb++;
      if (i == 1) begin
        chk("hd_adr", 1, 32'(mem_adr[1]), 32'h0ABCD);
        chk("hd_we", 1, 32'(mem_we[1]), 32'd1);
        #1 wb_stb[1] = 1'b0; wb_cyc[1] = 1'b0;
      end
    end
    chk("hd_stb_cycles", 1, 32'(n_stb), 32'd3);
    chk("hd_wb_acks", 1, 32'(n_wb), 32'd0);

    // Display read on LAT=3 proves the FSM returned to IDLE
    @(posedge clk); #1 wb_we[1] = 1'b0;
    csr_adr[1] = 17'h00042; mem_dat_r[1] = 16'h5A5A; csr_stb[1] = 1'b1;
    ack_i = -1;
    for (int i = 0; i < 10 && ack_i < 0; i++) begin
      @(negedge clk);
      if (csr_ack[1]) begin
        ack_i = i;
        chk("d3_csr_dat", 1, 32'(csr_dat[1]), 32'h5A5A);
      end
    end
    chk("d3_ack_cycle", 1, 32'(ack_i), 32'd4);
    @(posedge clk); #1 csr_stb[1] = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of a LAT=3 display access
    #1 csr_adr[1] = 17'h00777; mem_dat_r[1] = 16'h0F0F; csr_stb[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ra_stb_before", 1, 32'(mem_stb[1]), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ra_stb_dropped", 1, 32'(mem_stb[1]), 32'd0);
    chk("ra_no_ack", 1, 32'(csr_ack[1]), 32'd0);
    @(negedge clk);
    chk("ra_no_ack_late", 1, 32'(csr_ack[1]), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    ack_i = -1;
    for (int i = 0; i < 12 && ack_i < 0; i++) begin
      @(negedge clk);
      if (csr_ack[1]) begin
        ack_i = i;
        chk("ra_csr_dat", 1, 32'(csr_dat[1]), 32'h0F0F);
      end
    end
    chk("ra_regrant_cycle", 1, 32'(ack_i), 32'd4);
    @(posedge clk); #1 csr_stb[1] = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
